// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential 32-bit instruction fetch feeding a DEPTH-entry {pc, inst} prefetch queue, with flushing redirect
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  function automatic logic [31:0] rvcpu_pmem_ifetch(input logic [31:0] raddr);
    return raddr ^ 32'hA5A5_A5A5;
  endfunction
  typedef enum logic {REQ, WAIT} state_t;
  state_t        state;
  logic [31:0]   fetch_pc, resp_inst;
  logic [LW-1:0] lat_cnt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic          resp, byp, push, pop, issue;
  always_comb begin
    resp = state == WAIT && lat_cnt == '0 && !redirect_valid;
    resp_inst = '0;
    if (resp) resp_inst = rvcpu_pmem_ifetch(fetch_pc);
`ifdef IFQ_BYPASS_EN
    byp = resp && count == '0;
`else
    byp = 1'b0;
`endif
    push = resp && !(byp && out_ready);
    pop = count != '0 && out_ready && !redirect_valid;
    issue = state == REQ && count != (AW+1)'(DEPTH) && !redirect_valid;
  end
  assign out_valid = count != '0 || byp;
  assign out_pc = byp ? fetch_pc : pc_q[rd_ptr];
  assign out_inst = byp ? resp_inst : inst_q[rd_ptr];
  assign out_count = count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      lat_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      state <= REQ;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (issue) begin
        state <= WAIT;
        lat_cnt <= LW'(MEM_LATENCY - 1);
      end else if (state == WAIT) begin
        if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        else begin
          state <= REQ;
          fetch_pc <= fetch_pc + 32'd4;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clock)
    if (push) begin
      pc_q[wr_ptr] <= fetch_pc;
      inst_q[wr_ptr] <= resp_inst;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue with a DEPTH=4/latency-1 and a DEPTH=2/latency-3 instance
module tb_ifetch_queue;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
`ifdef IFQ_BYPASS_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 3;
`endif
  logic clock = 0, reset = 1;
  logic a_rv = 0, a_ready = 0, a_valid;
  logic [31:0] a_rpc = 0, a_pc, a_inst;
  logic [2:0] a_count;
  logic b_rv = 0, b_ready = 0, b_valid;
  logic [31:0] b_rpc = 0, b_pc, b_inst;
  logic [1:0] b_count;
  int errors = 0, checks = 0, cyc = 0, b_last = -1, k;
  logic [31:0] qa[$], qb[$];
  logic [31:0] ea, eb;

  ifetch_queue #(.DEPTH(4), .MEM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .redirect_valid(a_rv), .redirect_pc(a_rpc),
    .out_valid(a_valid), .out_ready(a_ready), .out_pc(a_pc), .out_inst(a_inst), .out_count(a_count));
  ifetch_queue #(.DEPTH(2), .MEM_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .redirect_valid(b_rv), .redirect_pc(b_rpc),
    .out_valid(b_valid), .out_ready(b_ready), .out_pc(b_pc), .out_inst(b_inst), .out_count(b_count));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (!reset) begin
    if (a_valid && a_ready && !a_rv) begin
      check("a_expected_output", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check("a_pc", a_pc, ea);
        check("a_inst", a_inst, ea ^ KEY);
      end
    end
    if (b_valid && b_ready && !b_rv) begin
      check("b_expected_output", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check("b_pc", b_pc, eb);
        check("b_inst", b_inst, eb ^ KEY);
      end
      if (b_last >= 0) check("b_interval", 32'(cyc - b_last), 32'd4);
      b_last = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_a(input logic [31:0] pc);
    a_ready = 0;
    a_rv = 1;
    a_rpc = pc;
    qa.delete();
    tick();
    a_rv = 0;
  endtask

  task automatic redirect_b(input logic [31:0] pc);
    b_ready = 0;
    b_rv = 1;
    b_rpc = pc;
    qb.delete();
    tick();
    b_rv = 0;
    b_last = -1;
  endtask

  task automatic first_a(output int n);
    n = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin
      @(negedge clock);
      if (a_valid) n = i;
    end
  endtask

  task automatic drain_a();
    a_ready = 1;
    for (int i = 0; i < 300 && qa.size() != 0; i++) @(posedge clock);
    #1 a_ready = 0;
    check("a_drain", 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b();
    b_ready = 1;
    for (int i = 0; i < 300 && qb.size() != 0; i++) @(posedge clock);
    #1 b_ready = 0;
    check("b_drain", 32'(qb.size()), 32'd0);
  endtask

  task automatic wait_count_a(input int n);
    for (int i = 0; i < 40 && 32'(a_count) != n; i++) @(negedge clock);
    check("a_fill", 32'(a_count), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    a_ready = 1;
    @(negedge clock);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    @(posedge clock);
    #1 reset = 0;
    qa.push_back(32'h8000_0000);
    qa.push_back(32'h8000_0004);
    qa.push_back(32'h8000_0008);
    first_a(k);
    check("a_first_valid_cycle", 32'(k), 32'(FIRST));
    drain_a();

    redirect_a(32'h8000_0000);
    repeat (20) tick();
    check("a_full_count", 32'(a_count), 32'd4);
    check("a_full_head", a_pc, 32'h8000_0000);
    repeat (3) tick();
    check("a_full_count_hold", 32'(a_count), 32'd4);
    check("a_full_head_hold", a_pc, 32'h8000_0000);
    check("a_full_inst_hold", a_inst, 32'h8000_0000 ^ KEY);
    for (int i = 0; i < 8; i++) qa.push_back(32'h8000_0000 + 32'(4 * i));
    a_ready = 1;
    repeat (4) tick();
    a_ready = 0;
    check("a_burst_left", 32'(qa.size()), 32'd4);
    drain_a();

    redirect_a(32'h8000_0300);
    wait_count_a(2);
    tick();
    redirect_a(32'h8000_0102);
    check("a_redir_count", 32'(a_count), 32'd0);
    check("a_redir_valid", 32'(a_valid), 32'd0);
    qa.push_back(32'h8000_0100);
    qa.push_back(32'h8000_0104);
    qa.push_back(32'h8000_0108);
    a_ready = 1;
    first_a(k);
    check("a_redir_first_valid_cycle", 32'(k), 32'(FIRST));
    drain_a();

    redirect_a(32'h8000_0500);
    wait_count_a(1);
    tick();
    a_rv = 1;
    a_rpc = 32'h8000_0200;
    a_ready = 1;
    qa.delete();
    tick();
    a_rv = 0;
    a_ready = 0;
    check("a_coll_count", 32'(a_count), 32'd0);
    check("a_coll_valid", 32'(a_valid), 32'd0);
    check("a_coll_rd_ptr", 32'(dut_a.rd_ptr), 32'd0);
    check("a_coll_wr_ptr", 32'(dut_a.wr_ptr), 32'd0);
    qa.push_back(32'h8000_0200);
    qa.push_back(32'h8000_0204);
    qa.push_back(32'h8000_0208);
    drain_a();

    redirect_b(32'h8000_1000);
    for (int i = 0; i < 10; i++) qb.push_back(32'h8000_1000 + 32'(4 * i));
    drain_b();
    redirect_b(32'hFFFF_FFFF);
    qb.push_back(32'hFFFF_FFFC);
    qb.push_back(32'h0000_0000);
    qb.push_back(32'h0000_0004);
    drain_b();

    redirect_a(32'h8000_0600);
    wait_count_a(3);
    tick();
    reset = 1;
    #1;
    check("a_midrst_valid", 32'(a_valid), 32'd0);
    check("a_midrst_count", 32'(a_count), 32'd0);
    check("b_midrst_count", 32'(b_count), 32'd0);
    tick();
    reset = 0;
    qa.delete();
    qa.push_back(32'h8000_0000);
    qa.push_back(32'h8000_0004);
    qa.push_back(32'h8000_0008);
    drain_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit with an internal prefetch queue. It fetches sequential 32-bit instructions from a start PC, reading memory through the DPI-C function `rvcpu_pmem_ifetch(raddr)`, and buffers up to `DEPTH` {pc, instruction} pairs for the decode stage. A redirect port lets execute/writeback flush the queue and restart fetch at a new PC. It replaces the single-entry, non-prefetching fetch stage between the PC generator and decode.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `MEM_LATENCY`, 1: cycles from request issue to data return; ≥1.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `redirect_valid` in 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: the head entry is valid.
- `out_ready` in 1: the consumer accepts the head entry.
- `out_pc` out 32: PC of the head entry.
- `out_inst` out 32: instruction of the head entry.
- `out_count` out $clog2(DEPTH)+1: number of queue entries occupied.

## Operation
- Fetch FSM states:
  - REQ: issue a request when `count < DEPTH` and no redirect is present, then go to WAIT with `lat_cnt = MEM_LATENCY-1`. Otherwise stay in REQ.
  - WAIT: while `lat_cnt != 0`, decrement it. When `lat_cnt == 0` (the response cycle):
    - call `rvcpu_pmem_ifetch(fetch_pc)`;
    - push {fetch_pc, data};
    - set `fetch_pc += 4`;
    - go to REQ.
- At most one request is outstanding. The issue condition guarantees no overflow: `count` cannot rise between issue and push.
- The queue is a circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits that wrap modulo `DEPTH`. `count` is tracked separately and is 0..DEPTH.
- Pop occurs on `out_valid & out_ready`. `out_valid = (count != 0)`. `out_pc`/`out_inst` are the head entry and are undefined when empty.
- A push and a pop in the same cycle leave `count` unchanged; both pointers advance.
- Redirect (highest priority) on a `redirect_valid` cycle:
  - `count`, `rd_ptr` and `wr_ptr` go to 0;
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`;
  - FSM goes to REQ;
  - any in-flight request is discarded with no DPI call;
  - a same-cycle push and pop are both suppressed.
- `fetch_pc` wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values: FSM=REQ, `fetch_pc=RESET_PC`, `count=0`, pointers 0, `lat_cnt=0`, `out_valid=0`, `out_count=0`. `out_pc`/`out_inst` are don't-care.
- Reset asserted mid-operation clears all state immediately; the in-flight request is dropped.
- Latency (macro off), with the request issued in cycle t:
  - response cycle is t+MEM_LATENCY;
  - `out_valid` rises in cycle t+MEM_LATENCY+1;
  - next issue is in cycle t+MEM_LATENCY+1.
- Steady-state throughput: one instruction per MEM_LATENCY+1 cycles while not full.
- After a redirect in cycle r: first issue in r+1; first `out_valid` at r+MEM_LATENCY+2.
- While `out_valid=1` and `out_ready=0`, the head entry is held stable.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - In a response cycle with `count==0` and no redirect, the response drives `out_valid=1`, `out_pc` and `out_inst` combinationally in that same cycle.
  - If `out_ready=1` that cycle, the entry is consumed and not written to the queue.
  - Otherwise it is pushed normally.
  - First `out_valid` after reset is therefore cycle MEM_LATENCY+1 instead of MEM_LATENCY+2 (counting the first post-reset cycle as 1).
- Undefined: no bypass; responses are always registered in the queue first.

## Test plan
- Reset release, `out_ready=1`, MEM_LATENCY=1, memory word at PC = PC ^ 32'hA5A5_A5A5 → `out_pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 with matching `out_inst`. First `out_valid` is on cycle 3 after reset release (macro off) or cycle 2 (macro on).
- `out_ready=0`, DEPTH=4 → `out_count` reaches 4, no further DPI calls, and head stays 0x8000_0000. Then `out_ready=1` for 4 cycles → entries drain in order and fetch resumes.
- Redirect to 0x8000_0102 while in WAIT with the queue holding 2 entries → `out_count=0` next cycle, the dropped request makes no DPI call, and the next `out_pc` is 0x8000_0100.
- Redirect in the same cycle as a push and a pop → `count` is 0, the pushed entry is discarded, and the pointers are 0.
- MEM_LATENCY=3, DEPTH=2, pointer wrap over 10 instructions → one instruction every 4 cycles and no reordering across the wrap. A redirect to 0xFFFF_FFFC yields `out_pc` 0xFFFF_FFFC then 0x0000_0000.
- Assert `reset` mid-WAIT with 3 entries queued → `out_valid=0` and `out_count=0` immediately. After release, fetch restarts at 0x8000_0000.
